gray_burst_arbiter: RTL and testbench

GRAY_BURST_ARBITER -- requirements
Module: gray_burst_arbiter

---
 rtl/gray_burst_arbiter.sv | 133 +++++++++++++
 tb/tb_gray_burst_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_burst_arbiter.sv
// Two-requester round-robin arbiter that runs one burst at a time on a shared 3-bit Gray counter.
// Each burst is an optional clear, Len step cycles and a finish cycle. The finish cycle reports Result, owner and wrap status.
module gray_burst_arbiter (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Req0,
   input  logic       Req1,
   input  logic [3:0] Len0,
   input  logic [3:0] Len1,
   input  logic       Clr0,
   input  logic       Clr1,
   input  logic [2:0] CntValue,
   output logic       Gnt0,
   output logic       Gnt1,
   output logic       CntEn,
   output logic       CntClr,
   output logic       Busy,
   output logic       Done,
   output logic       DoneId,
   output logic [2:0] Result,
   output logic       Wrapped
);

   localparam int unsigned LEN_W = 4;
   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] WRAP_VAL = CNT_W'(3'b100);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STEP, S_FINISH} state_t;

   state_t             r_state;
   logic               r_prio;
   logic               r_id;
   logic               r_flag;
   logic [LEN_W-1:0]   r_rem;
   logic               r_cnt_en;
   logic               r_cnt_clr;
   logic               r_busy;
   logic               r_done;
   logic               r_done_id;
   logic [CNT_W-1:0]   r_result;
   logic               r_wrapped;

   logic               w_grant;
   logic               w_win;
   logic [LEN_W-1:0]   w_len;
   logic               w_clr;

   // Grant is decided in the IDLE cycle itself so a burst can start in the Done cycle.
   assign w_grant = !Reset && (r_state == S_IDLE) && (Req0 || Req1);
   assign w_win   = (Req0 && Req1) ? r_prio : Req1;
   assign w_len   = w_win ? Len1 : Len0;
   assign w_clr   = w_win ? Clr1 : Clr0;

   assign Gnt0    = w_grant && !w_win;
   assign Gnt1    = w_grant && w_win;
   assign CntEn   = r_cnt_en;
   assign CntClr  = r_cnt_clr;
   assign Busy    = r_busy;
   assign Done    = r_done;
   assign DoneId  = r_done_id;
   assign Result  = r_result;
   assign Wrapped = r_wrapped;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_prio    <= 1'b0;
         r_id      <= 1'b0;
         r_flag    <= 1'b0;
         r_rem     <= '0;
         r_cnt_en  <= 1'b0;
         r_cnt_clr <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_done_id <= 1'b0;
         r_result  <= '0;
         r_wrapped <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_id   <= w_win;
                  r_prio <= !w_win;
                  r_rem  <= w_len;
                  r_flag <= 1'b0;
                  r_busy <= 1'b1;
                  if (w_clr) begin
                     r_state   <= S_CLEAR;
                     r_cnt_clr <= 1'b1;
                  end else if (w_len != '0) begin
                     r_state  <= S_STEP;
                     r_cnt_en <= 1'b1;
                  end else begin
                     r_state <= S_FINISH;
                  end
               end
            end
            S_CLEAR: begin
               r_cnt_clr <= 1'b0;
               if (r_rem != '0) begin
                  r_state  <= S_STEP;
                  r_cnt_en <= 1'b1;
               end else begin
                  r_state <= S_FINISH;
               end
            end
            S_STEP: begin
               // The counter passes 100->000 on the step taken while it shows 100.
               if (CntValue == WRAP_VAL) r_flag <= 1'b1;
               if (r_rem == LEN_W'(1)) begin
                  r_state  <= S_FINISH;
                  r_cnt_en <= 1'b0;
               end else begin
                  r_rem <= r_rem - LEN_W'(1);
               end
            end
            S_FINISH: begin
               r_state   <= S_IDLE;
               r_busy    <= 1'b0;
               r_done    <= 1'b1;
               r_result  <= CntValue;
               r_done_id <= r_id;
               r_wrapped <= r_flag;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gray_burst_arbiter.sv
// Directed bench for gray_burst_arbiter with a behavioural 3-bit Gray counter on CntEn/CntClr.
module tb_gray_burst_arbiter;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Req0 = 1'b0, Req1 = 1'b0;
   logic [3:0] Len0 = 4'd0, Len1 = 4'd0;
   logic       Clr0 = 1'b0, Clr1 = 1'b0;
   logic [2:0] CntValue;
   logic       Gnt0, Gnt1, CntEn, CntClr, Busy, Done, DoneId, Wrapped;
   logic [2:0] Result;

   logic [2:0] cnt = 3'b000;
   logic       ld = 1'b0;
   logic [2:0] ld_val = 3'b000;
   int         n_en_tot = 0;
   int         n_clr_tot = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   gray_burst_arbiter dut (
      .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Len0(Len0), .Len1(Len1),
      .Clr0(Clr0), .Clr1(Clr1), .CntValue(CntValue), .Gnt0(Gnt0), .Gnt1(Gnt1),
      .CntEn(CntEn), .CntClr(CntClr), .Busy(Busy), .Done(Done), .DoneId(DoneId),
      .Result(Result), .Wrapped(Wrapped)
   );

   always #5 Clk = ~Clk;

   function automatic logic [2:0] gray_next(input logic [2:0] g);
      case (g)
         3'b000: gray_next = 3'b001;
         3'b001: gray_next = 3'b011;
         3'b011: gray_next = 3'b010;
         3'b010: gray_next = 3'b110;
         3'b110: gray_next = 3'b111;
         3'b111: gray_next = 3'b101;
         3'b101: gray_next = 3'b100;
         default: gray_next = 3'b000;
      endcase
   endfunction

   // External counter the block steers
   always @(posedge Clk) begin
      if (ld) cnt <= ld_val;
      else if (CntClr) cnt <= 3'b000;
      else if (CntEn) cnt <= gray_next(cnt);
   end
   assign CntValue = cnt;

   always @(negedge Clk) begin
      if (CntEn === 1'b1) n_en_tot++;
      if (CntClr === 1'b1) n_clr_tot++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk); #1;
   endtask

   task automatic load_cnt(input logic [2:0] v);
      ld = 1'b1; ld_val = v;
      tick();
      ld = 1'b0;
   endtask

   // Drives one burst from IDLE and measures it; comparisons stay in the scenario tasks.
   task automatic run_burst(input bit id, input logic [3:0] len, input bit clr, input logic [2:0] init,
                            output logic [1:0] g, output int lat, output int en, output int cl);
      int en0, cl0;
      load_cnt(init);
      en0 = n_en_tot; cl0 = n_clr_tot;
      if (id) begin Req1 = 1'b1; Len1 = len; Clr1 = clr; end
      else    begin Req0 = 1'b1; Len0 = len; Clr0 = clr; end
      #1 g = {Gnt1, Gnt0};
      tick();
      Req0 = 1'b0; Req1 = 1'b0;
      lat = 1;
      while (Done !== 1'b1 && lat < 40) begin tick(); lat++; end
      en = n_en_tot - en0;
      cl = n_clr_tot - cl0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Req0 = 1'b1; Req1 = 1'b1;
      tick(); tick();
      n_checks++;
      if ({Gnt0, Gnt1} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", {Gnt0, Gnt1}); end
      n_checks++;
      if ({CntEn, CntClr, Busy, Done} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl: got %b expected 0000", {CntEn, CntClr, Busy, Done}); end
      n_checks++;
      if ({DoneId, Result, Wrapped} !== 5'b00000) begin n_fail++; $display("FAIL reset_res: got %b expected 00000", {DoneId, Result, Wrapped}); end
      Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
      tick();
   endtask

   task automatic test_clear_burst();
      logic [1:0] g; int lat, en, cl;
      // Counter starts nonzero so the clear is visible in the Result.
      run_burst(1'b0, 4'd3, 1'b1, 3'b101, g, lat, en, cl);
      n_checks++; if (g !== 2'b01) begin n_fail++; $display("FAIL clr_gnt: got %b expected 01", g); end
      n_checks++; if (lat != 6) begin n_fail++; $display("FAIL clr_lat: got %0d expected 6", lat); end
      n_checks++; if (en != 3) begin n_fail++; $display("FAIL clr_en: got %0d expected 3", en); end
      n_checks++; if (cl != 1) begin n_fail++; $display("FAIL clr_clr: got %0d expected 1", cl); end
      n_checks++;
      if ({DoneId, Result, Wrapped} !== {1'b0, 3'b010, 1'b0}) begin
         n_fail++; $display("FAIL clr_res: got id=%b res=%b wr=%b expected id=0 res=010 wr=0", DoneId, Result, Wrapped);
      end
   endtask

   task automatic test_wrap();
      logic [1:0] g; int lat, en, cl;
      run_burst(1'b1, 4'd4, 1'b0, 3'b110, g, lat, en, cl);
      n_checks++; if (g !== 2'b10) begin n_fail++; $display("FAIL wrap_gnt: got %b expected 10", g); end
      n_checks++; if (lat != 6) begin n_fail++; $display("FAIL wrap_lat: got %0d expected 6", lat); end
      n_checks++; if (en != 4 || cl != 0) begin n_fail++; $display("FAIL wrap_cnt: got en=%0d clr=%0d expected en=4 clr=0", en, cl); end
      n_checks++;
      if ({DoneId, Result, Wrapped} !== {1'b1, 3'b000, 1'b1}) begin
         n_fail++; $display("FAIL wrap_res: got id=%b res=%b wr=%b expected id=1 res=000 wr=1", DoneId, Result, Wrapped);
      end
   endtask

   task automatic test_zero_len();
      logic [1:0] g; int lat, en, cl;
      run_burst(1'b0, 4'd0, 1'b0, 3'b011, g, lat, en, cl);
      n_checks++; if (g !== 2'b01) begin n_fail++; $display("FAIL zero_gnt: got %b expected 01", g); end
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL zero_lat: got %0d expected 2", lat); end
      n_checks++; if (en != 0 || cl != 0) begin n_fail++; $display("FAIL zero_cnt: got en=%0d clr=%0d expected 0 0", en, cl); end
      n_checks++;
      if ({DoneId, Result, Wrapped} !== {1'b0, 3'b011, 1'b0}) begin
         n_fail++; $display("FAIL zero_res: got id=%b res=%b wr=%b expected id=0 res=011 wr=0", DoneId, Result, Wrapped);
      end
      // Results must hold after Done while the counter moves on.
      load_cnt(3'b101);
      tick(); tick();
      n_checks++;
      if ({Done, DoneId, Result, Wrapped} !== {1'b0, 1'b0, 3'b011, 1'b0}) begin
         n_fail++; $display("FAIL hold_res: got done=%b id=%b res=%b wr=%b expected 0 0 011 0", Done, DoneId, Result, Wrapped);
      end
   endtask

   task automatic test_long_burst();
      logic [1:0] g; int lat, en, cl;
      run_burst(1'b1, 4'd15, 1'b1, 3'b010, g, lat, en, cl);
      n_checks++; if (g !== 2'b10) begin n_fail++; $display("FAIL long_gnt: got %b expected 10", g); end
      n_checks++; if (lat != 18) begin n_fail++; $display("FAIL long_lat: got %0d expected 18", lat); end
      n_checks++; if (en != 15 || cl != 1) begin n_fail++; $display("FAIL long_cnt: got en=%0d clr=%0d expected 15 1", en, cl); end
      n_checks++;
      if ({DoneId, Result, Wrapped} !== {1'b1, 3'b100, 1'b1}) begin
         n_fail++; $display("FAIL long_res: got id=%b res=%b wr=%b expected id=1 res=100 wr=1", DoneId, Result, Wrapped);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_g [3];
      logic       exp_id [3];
      int lat; bit stray;
      exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b00;
      exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0;
      Reset = 1'b1; tick(); Reset = 1'b0;
      Len0 = 4'd1; Len1 = 4'd1; Clr0 = 1'b0; Clr1 = 1'b0;
      Req0 = 1'b1; Req1 = 1'b1;
      #1;
      n_checks++; if ({Gnt1, Gnt0} !== 2'b01) begin n_fail++; $display("FAIL b2b_first: got %b expected 01", {Gnt1, Gnt0}); end
      stray = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k == 2) begin Req0 = 1'b0; Req1 = 1'b0; end
         lat = 1;
         while (Done !== 1'b1 && lat < 20) begin
            if (Gnt0 || Gnt1) stray = 1'b1;
            tick(); lat++;
         end
         n_checks++;
         if (lat != 3 || {Gnt1, Gnt0} !== exp_g[k] || DoneId !== exp_id[k]) begin
            n_fail++;
            $display("FAIL b2b_burst%0d: got lat=%0d gnt=%b id=%b expected lat=3 gnt=%b id=%b",
                     k, lat, {Gnt1, Gnt0}, DoneId, exp_g[k], exp_id[k]);
         end
      end
      n_checks++; if (stray) begin n_fail++; $display("FAIL b2b_busy_gnt: got grant while busy expected none"); end
   endtask

   task automatic test_reset_mid_burst();
      int en0, cl0, lat; bit seen;
      load_cnt(3'b000);
      en0 = n_en_tot; cl0 = n_clr_tot;
      Req0 = 1'b1; Len0 = 4'd5; Clr0 = 1'b0;
      #1;
      n_checks++; if (Gnt0 !== 1'b1) begin n_fail++; $display("FAIL mid_gnt: got %b expected 1", Gnt0); end
      tick(); Req0 = 1'b0;
      tick(); Reset = 1'b1;
      tick(); Reset = 1'b0;
      n_checks++;
      if ({CntEn, Busy, CntClr} !== 3'b000) begin n_fail++; $display("FAIL mid_abort: got en/busy/clr=%b expected 000", {CntEn, Busy, CntClr}); end
      seen = 1'b0;
      repeat (10) begin if (Done !== 1'b0) seen = 1'b1; tick(); end
      n_checks++; if (seen) begin n_fail++; $display("FAIL mid_done: got Done after abort expected none"); end
      n_checks++;
      if (n_en_tot - en0 != 2 || n_clr_tot - cl0 != 0) begin
         n_fail++; $display("FAIL mid_steps: got en=%0d clr=%0d expected 2 0", n_en_tot - en0, n_clr_tot - cl0);
      end
      Len0 = 4'd0; Len1 = 4'd0; Clr1 = 1'b0;
      Req0 = 1'b1; Req1 = 1'b1;
      #1;
      n_checks++; if ({Gnt1, Gnt0} !== 2'b01) begin n_fail++; $display("FAIL mid_prio: got %b expected 01", {Gnt1, Gnt0}); end
      tick(); Req0 = 1'b0; Req1 = 1'b0;
      lat = 1;
      while (Done !== 1'b1 && lat < 20) begin tick(); lat++; end
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL mid_after: got lat=%0d expected 2", lat); end
   endtask

   initial begin
      test_reset();
      test_clear_burst();
      test_wrap();
      test_zero_len();
      test_long_burst();
      test_back_to_back();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
